// File: rtl/debounce_bank_pkg.sv
// Shared helpers for the debounce bank: width calculation for prescaler and counters.
package debounce_bank_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: two-flop synchroniser, stability counter, clean level and edge strobes.
module debounce_chan
  import debounce_bank_pkg::*;
#(
  parameter int   STABLE_TICKS = 10,
  parameter int   CW           = 4,
  parameter logic INIT         = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  input  logic tick,
  input  logic filt_en,
  output logic out,
  output logic rise,
  output logic fall
);

  logic [1:0]    sync_pipe;
  logic [CW-1:0] cnt;
  logic          sync;

  assign sync = sync_pipe[1];

  // Only sync_pipe[0] may go metastable; nothing else looks at it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_pipe <= {2{INIT}};
    else          sync_pipe <= {sync_pipe[0], in};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      out  <= INIT;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (!filt_en) begin
        cnt <= '0;
        if (tick) out <= sync;
      end else if (sync == out) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CW'(STABLE_TICKS - 1)) begin
          out  <= sync;
          cnt  <= '0;
          rise <= sync;
          fall <= ~sync;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: shared sample prescaler, settle/ready sequencing, per-channel filters.
module debounce_bank
  import debounce_bank_pkg::*;
#(
  parameter int                  CHANNELS     = 8,
  parameter int                  DIV          = 32768,
  parameter int                  STABLE_TICKS = 10,
  parameter logic [CHANNELS-1:0] INIT         = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                ready,
  output logic                tick
);

  localparam int PW = clog2(DIV);
  localparam int IW = clog2(STABLE_TICKS + 1);
  localparam int CW = clog2(STABLE_TICKS);

  logic [PW-1:0] pcnt;
  logic [IW-1:0] icnt;
  logic          ready_q;
  logic          settle_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (pcnt == PW'(DIV - 1));
      if (pcnt == PW'(DIV - 1)) pcnt <= '0;
      else                      pcnt <= pcnt + 1'b1;
    end
  end

  // ready is visible during the final settle tick; the channels only start
  // filtering from the registered flag, i.e. on the following tick.
  assign settle_done = tick & ~ready_q & (icnt == IW'(STABLE_TICKS - 1));
  assign ready       = ready_q | settle_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      icnt    <= '0;
      ready_q <= 1'b0;
    end else if (tick && !ready_q) begin
      icnt <= icnt + 1'b1;
      if (settle_done) ready_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS),
      .CW          (CW),
      .INIT        (INIT[g])
    ) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .in     (in[g]),
      .tick   (tick),
      .filt_en(ready_q),
      .out    (out[g]),
      .rise   (rise[g]),
      .fall   (fall[g])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised bench for debounce_bank against a tick-counting behavioural model.
module tb_debounce_bank;
  localparam int        CH   = 4;
  localparam int        DIV  = 4;
  localparam int        ST   = 3;
  localparam logic [3:0] INIT = 4'b0000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] in = INIT;
  logic [3:0] out, rise, fall;
  logic       ready, tick;

  always #5 clk = ~clk;

  debounce_bank #(.CHANNELS(CH), .DIV(DIV), .STABLE_TICKS(ST), .INIT(INIT)) dut (
    .clk(clk), .reset_n(reset_n), .in(in), .out(out), .rise(rise), .fall(fall),
    .ready(ready), .tick(tick)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: edges since release give the tick phase, the synchronised
  // value is the input seen two edges ago, and a channel flips once it has
  // disagreed with its clean level for ST consecutive sampled ticks.
  int         e, seen;
  int         streak[CH];
  logic       m_rq, m_tick;
  logic [3:0] m_out, m_rise, m_fall, q0, q1;

  function automatic logic m_ready();
    return m_rq | (m_tick && seen == ST - 1);
  endfunction

  task automatic mreset();
    e = 0; seen = 0; m_rq = 1'b0; m_tick = 1'b0;
    m_out = INIT; m_rise = '0; m_fall = '0; q0 = INIT; q1 = INIT;
    for (int i = 0; i < CH; i++) streak[i] = 0;
  endtask

  task automatic mstep();
    logic [3:0] sy;
    sy = q1;
    m_rise = '0; m_fall = '0;
    if (!m_rq) begin
      for (int i = 0; i < CH; i++) streak[i] = 0;
      if (m_tick) begin
        m_out = sy;
        seen++;
        if (seen == ST) m_rq = 1'b1;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (sy[i] == m_out[i]) streak[i] = 0;
        else if (m_tick) begin
          streak[i]++;
          if (streak[i] == ST) begin
            m_out[i] = sy[i];
            if (sy[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
            streak[i] = 0;
          end
        end
      end
    end
    q1 = q0; q0 = in;
    e++;
    m_tick = (e % DIV == 0);
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) mreset();
      else          mstep();
    end
  end

  logic chk_on = 1'b0;
  int   strobe_cnt = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("out", out, m_out);
      chk("rise", rise, m_rise);
      chk("fall", fall, m_fall);
      chk("ready", ready, m_ready());
      chk("tick", tick, m_tick);
      chk("excl", |(rise & fall), 1'b0);
      strobe_cnt += $countones(rise | fall);
    end
  end

  task automatic nclk(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    do begin nclk(1); n++; end while (!ready && n < 100);
    chk(tag, n, ST * DIV);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    // reset, constant pattern, settle
    in = 4'b1010;
    nclk(3);
    chk("rst_out", out, INIT);
    chk("rst_ready", ready, 1'b0);
    chk("rst_tick", tick, 1'b0);
    chk("rst_strobe", rise | fall, 4'b0000);
    chk_on = 1'b1;
    reset_n = 1'b1;
    wait_ready("rdy_lat");
    nclk(10);
    chk("p1_out", out, 4'b1010);
    chk("p1_strobes", strobe_cnt, 0);

    // clean step on in[0], random tick phase
    nclk($urandom_range(0, 7));
    base = strobe_cnt;
    in[0] = 1'b1;
    n = 0;
    do begin nclk(1); n++; end while (!out[0] && n < 40);
    chk("p2_lat", (n >= (ST - 1) * DIV + 3 && n <= ST * DIV + 2), 1'b1);
    chk("p2_rise", rise, 4'b0001);
    nclk(1);
    chk("p2_rise_clr", rise, 4'b0000);
    chk("p2_strobes", strobe_cnt - base, 1);

    // short excursions on in[1] never propagate
    base = strobe_cnt;
    repeat (10) begin
      in[1] = 1'b0; nclk(3);
      in[1] = 1'b1; nclk(3);
    end
    nclk(20);
    chk("p3_out1", out[1], 1'b1);
    chk("p3_strobes", strobe_cnt - base, 0);

    // simultaneous flips on channels 2 and 3
    in[2] = 1'b1; in[3] = 1'b0;
    n = 0;
    do begin nclk(1); n++; end while (!(rise[2] | fall[3]) && n < 40);
    chk("p4_rise", rise, 4'b0100);
    chk("p4_fall", fall, 4'b1000);
    nclk(3);

    // glitch back to the clean level restarts the count
    n = 0;
    do begin nclk(1); n++; end while (!tick && n < 20);
    in[0] = 1'b0;
    nclk(9);
    in[0] = 1'b1;
    nclk(1);
    in[0] = 1'b0;
    nclk(4);
    chk("p5_hold", out[0], 1'b1);
    n = 4;
    do begin nclk(1); n++; end while (!fall[0] && n < 40);
    chk("p5_flip", n, 2 * DIV + 3);

    // random activity, checked cycle by cycle against the model
    repeat (60) begin
      in = in ^ 4'($urandom_range(0, 15));
      nclk($urandom_range(1, 16));
    end

    // async reset while channel 0 is mid-count and channel 3 strobes
    in = 4'b0000;
    nclk(30);
    in[3] = 1'b1;
    nclk(6 + $urandom_range(0, 1));
    in[0] = 1'b1;
    n = 0;
    do begin nclk(1); n++; end while (!rise[3] && n < 40);
    chk("p6_rise3", rise[3], 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("p6_out", out, INIT);
    chk("p6_rise", rise, 4'b0000);
    chk("p6_ready", ready, 1'b0);
    chk("p6_tick", tick, 1'b0);
    nclk(2);
    reset_n = 1'b1;
    wait_ready("p6_rdy_lat");
    nclk(10);
    chk("p6_resettle", out, 4'b1001);

    nclk(4);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parameterised, multi-channel successor to the single-input switch debouncer.
- Filters CHANNELS asynchronous inputs (panel switches, buttons, console lines) against one shared, programmable-rate sample tick.
- Each channel has a two-flop synchroniser, a per-channel stability counter, a registered clean level, and one-cycle rise/fall strobes.
- A bank-level ready flag replaces the old "output high until first slow tick" power-on hack. The block sits between board I/O pins and front-panel/control logic.

Parameters:
- CHANNELS, 8, number of independent input channels (1..32).
- DIV, 32768, clk cycles per sample tick (>=2).
- STABLE_TICKS, 10, consecutive ticks an input must differ from the clean level before the clean level flips (2..1023).
- INIT, 0, CHANNELS-bit reset value of the clean outputs.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in  in  CHANNELS  raw asynchronous inputs
- out  out  CHANNELS  debounced level
- rise  out  CHANNELS  one-cycle strobe, out bit went 0->1
- fall  out  CHANNELS  one-cycle strobe, out bit went 1->0
- ready  out  1  high once the initial settle period has completed
- tick  out  1  one-cycle sample strobe, exported for test/sharing

Behaviour:
- Reset (async assert, sync release):
  - Prescaler = 0, synchronisers = INIT, counters = 0, out = INIT.
  - rise = fall = 0, ready = 0, tick = 0, init counter = 0.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - tick is registered and high for exactly one clk in the cycle after the count equals DIV-1, so ticks arrive every DIV cycles.
  - First tick after reset release occurs DIV cycles after release.
- Synchroniser: two flops per channel, giving 2-cycle latency to sync[i]. Metastability is confined to the first stage.
- Settle phase (ready = 0):
  - Each tick copies sync into out unfiltered, and increments the init counter.
  - rise/fall are held 0.
  - When the init counter reaches STABLE_TICKS on a tick, ready goes high in that same cycle and stays high until reset.
  - Per-channel counters are held at 0 during settle.
- Filter phase (ready = 1), per channel i, evaluated every clk:
  - If sync[i] == out[i]: cnt[i] <= 0, regardless of tick. Any glitch back to the clean level restarts the count.
  - If sync[i] != out[i] and tick: if cnt[i] == STABLE_TICKS-1, then out[i] <= sync[i], cnt[i] <= 0, and rise[i] or fall[i] <= 1 on the same edge. Otherwise cnt[i] <= cnt[i]+1.
  - If sync[i] != out[i] and no tick: cnt[i] holds.
  - rise/fall are cleared on the next clk. They never assert together for one channel. Multiple channels may strobe in the same cycle.
- Latency: a clean step on in[i] reaches out[i] after 2 sync cycles plus STABLE_TICKS ticks. That is between (STABLE_TICKS-1)*DIV+3 and STABLE_TICKS*DIV+2 clks, depending on tick phase.
- Counter width is clog2(STABLE_TICKS). The counter never exceeds STABLE_TICKS-1, so no wrap is possible.
- Boundaries:
  - An input toggling faster than one tick period never propagates.
  - Input returning to the clean level on the same cycle as the final tick means no flip, since the equality test uses the current sync value.
  - reset_n asserted mid-count or mid-strobe: all state returns to reset values immediately and the settle phase restarts.
  - Ready rising in the same cycle as a tick: filtering starts from the following tick.

Decomposition:
- Shared package: none needed beyond the clog2 helper already in the common include.
- Natural sub-module: debounce_chan (synchroniser + counter + out/rise/fall for one bit), instantiated CHANNELS times by generate.
- Prescaler and ready logic live in debounce_bank.
- Target RTL is about 150-200 lines total.

Test Plan (bench parameters CHANNELS=4, DIV=4, STABLE_TICKS=3, INIT=4'b0000):
- Reset then in=4'b1010 held constant: ready rises 12 clks after release; out=4'b1010 with no rise/fall strobes at any time.
- After ready, in[0] 0->1 held: out[0] rises 11-14 clks later; rise[0] is a single-cycle pulse coincident with the edge; other channels stay quiet.
- After ready, in[1] pulses high for 3 clks, then low, repeated every 6 clks for 60 clks: out[1] never changes; rise/fall never assert.
- in[2] and in[3] toggled on the same clk: out[2] and out[3] flip on the same edge; rise/fall strobes are simultaneous on the correct bits.
- in[0] high for 2 ticks, then low for 1 clk spanning no tick, then high: the count restarts, and out[0] flips 3 full ticks after the glitch.
- reset_n pulled low while cnt[0]=2 and rise[3]=1: out=0, rise=0, and ready=0 immediately (async); the settle sequence repeats after release.
